exunit_fpga: RTL and testbench

EXUNIT_FPGA -- requirements
Module: exunit_fpga

---
 rtl/exunit_fpga.sv | 169 ++++++++++++++++
 tb/tb_exunit_fpga.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exunit_fpga.sv
// ----------------------------------------------------------------------------
// exunit_fpga : pipelined 32x32 multiply execution unit
//
// Accepts one multiply per cycle with no back-pressure and broadcasts the
// selected product word STAGES cycles later. Speculative ops ride along with
// their one-hot branch tag and are squashed in flight on a mispredict, or
// made non-speculative when their branch resolves.
//
// Ports
//   clk, reset            clock, synchronous active-low reset
//   issue_valid           op issued this cycle (always accepted)
//   ex_src1, ex_src2      operands
//   rrftag, dstval        destination rename tag / op writes a destination
//   spectag, specbit      one-hot branch tag / op is speculative
//   src1_signed,
//   src2_signed           operand signedness
//   sel_lohi              0: product[31:0], 1: product[63:32]
//   prmiss, prsuccess     branch mispredict / branch resolved
//   prtag                 tag of the resolved branch
//   specfixtag            mask of branch tags killed by a mispredict
//   exrslt, exdst         result broadcast and its tag
//   kill_spec             consumers ignore exrslt/exdst this cycle
//   rrf_we                rename-register file write enable
//   rob_we, rob_tag       ROB completion strobe and entry
// ----------------------------------------------------------------------------
module exunit_fpga #(
  parameter int  STAGES      = 3,
  localparam int DATA_LEN    = 32,
  localparam int RRF_SEL     = 6,
  localparam int SPECTAG_LEN = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [DATA_LEN-1:0]    ex_src1,
  input  logic [DATA_LEN-1:0]    ex_src2,
  input  logic [RRF_SEL-1:0]     rrftag,
  input  logic                   dstval,
  input  logic [SPECTAG_LEN-1:0] spectag,
  input  logic                   specbit,
  input  logic                   src1_signed,
  input  logic                   src2_signed,
  input  logic                   sel_lohi,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  input  logic [SPECTAG_LEN-1:0] specfixtag,
  output logic [DATA_LEN-1:0]    exrslt,
  output logic [RRF_SEL-1:0]     exdst,
  output logic                   kill_spec,
  output logic                   rrf_we,
  output logic                   rob_we,
  output logic [RRF_SEL-1:0]     rob_tag
);

  localparam int L = STAGES - 1;

  // An op on a killed branch path: speculative and its tag is in the kill mask.
  function automatic logic kill_hit(input logic                   miss,
                                    input logic                   sb,
                                    input logic [SPECTAG_LEN-1:0] tag,
                                    input logic [SPECTAG_LEN-1:0] fix);
    return miss & sb & (|(tag & fix));
  endfunction

  // Resolution only counts when no mispredict arrives in the same cycle.
  function automatic logic resolve_hit(input logic                   miss,
                                       input logic                   succ,
                                       input logic [SPECTAG_LEN-1:0] tag,
                                       input logic [SPECTAG_LEN-1:0] pt);
    return succ & ~miss & (tag == pt);
  endfunction

  // The low 64 bits of the 33x33 signed product equal the low 64 bits of the
  // product of the same operands extended straight to 64 bits.
  function automatic logic [DATA_LEN-1:0] mul_word(input logic [DATA_LEN-1:0] a,
                                                   input logic [DATA_LEN-1:0] b,
                                                   input logic                as,
                                                   input logic                bs,
                                                   input logic                sel);
    logic signed [2*DATA_LEN-1:0] ea;
    logic signed [2*DATA_LEN-1:0] eb;
    logic signed [2*DATA_LEN-1:0] prod;
    ea   = {{DATA_LEN{as & a[DATA_LEN-1]}}, a};
    eb   = {{DATA_LEN{bs & b[DATA_LEN-1]}}, b};
    prod = ea * eb;
    return sel ? prod[2*DATA_LEN-1:DATA_LEN] : prod[DATA_LEN-1:0];
  endfunction

  // Per-stage control/tag state; index 0 is stage 1, index L is the output.
  logic                   vld_p     [STAGES];
  logic                   specbit_p [STAGES];
  logic                   dstval_p  [STAGES];
  logic [SPECTAG_LEN-1:0] spectag_p [STAGES];
  logic [RRF_SEL-1:0]     rrftag_p  [STAGES];
  // Selected product word exists from stage 2 onward.
  logic [DATA_LEN-1:0]    rslt_p    [1:STAGES-1];

  // Stage 1 operand payload.
  logic [DATA_LEN-1:0]    src1_p0;
  logic [DATA_LEN-1:0]    src2_p0;
  logic                   src1_signed_p0;
  logic                   src2_signed_p0;
  logic                   sel_lohi_p0;

  logic                   kill_out;

  // ---- issue -> stage 1 -> ... -> output : control ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        vld_p[i]     <= 1'b0;
        specbit_p[i] <= 1'b0;
      end
    end else begin
      vld_p[0]     <= issue_valid & ~kill_hit(prmiss, specbit, spectag, specfixtag);
      specbit_p[0] <= specbit & ~resolve_hit(prmiss, prsuccess, spectag, prtag);
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i]     <= vld_p[i-1] &
                        ~kill_hit(prmiss, specbit_p[i-1], spectag_p[i-1], specfixtag);
        specbit_p[i] <= specbit_p[i-1] &
                        ~resolve_hit(prmiss, prsuccess, spectag_p[i-1], prtag);
      end
    end
  end

  // ---- issue -> stage 1 -> ... -> output : tags and operands ----
  always_ff @(posedge clk) begin
    dstval_p[0]    <= dstval;
    spectag_p[0]   <= spectag;
    src1_p0        <= ex_src1;
    src2_p0        <= ex_src2;
    src1_signed_p0 <= src1_signed;
    src2_signed_p0 <= src2_signed;
    sel_lohi_p0    <= sel_lohi;
    for (int i = 1; i < STAGES; i++) begin
      dstval_p[i]  <= dstval_p[i-1];
      spectag_p[i] <= spectag_p[i-1];
    end
  end

  // ---- stage 1 -> stage 2 multiply, then shift to output ----
  // Only the output-stage copies are cleared so the broadcast bus reads zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rrftag_p[L] <= '0;
      rslt_p[L]   <= '0;
    end else begin
      rrftag_p[0] <= rrftag;
      for (int i = 1; i < STAGES; i++) begin
        rrftag_p[i] <= rrftag_p[i-1];
      end
      rslt_p[1] <= mul_word(src1_p0, src2_p0, src1_signed_p0, src2_signed_p0, sel_lohi_p0);
      for (int i = 2; i < STAGES; i++) begin
        rslt_p[i] <= rslt_p[i-1];
      end
    end
  end

  // ---- output stage broadcast ----
  assign kill_out  = kill_hit(prmiss, specbit_p[L], spectag_p[L], specfixtag);
  assign kill_spec = ~vld_p[L] | ~dstval_p[L] | kill_out;
  assign rrf_we    = vld_p[L] & dstval_p[L] & ~kill_out;
  assign rob_we    = vld_p[L] & ~kill_out;
  assign exrslt    = rslt_p[L];
  assign exdst     = rrftag_p[L];
  assign rob_tag   = rrftag_p[L];

endmodule

// File: tb/tb_exunit_fpga.sv
// ----------------------------------------------------------------------------
// tb_exunit_fpga : self-checking bench for exunit_fpga
//
// Directed sequences for the named scenarios, then a long randomized run.
// A reference model tracks every issued op as a record with an age; each
// cycle it applies mispredict/resolve rules to records that still advance
// and predicts the broadcast of the record whose age equals STAGES.
// ----------------------------------------------------------------------------
module tb_exunit_fpga;

  localparam int STAGES = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [31:0] ex_src1, ex_src2;
  logic [5:0]  rrftag;
  logic        dstval;
  logic [4:0]  spectag;
  logic        specbit;
  logic        src1_signed, src2_signed, sel_lohi;
  logic        prmiss, prsuccess;
  logic [4:0]  prtag, specfixtag;
  logic [31:0] exrslt;
  logic [5:0]  exdst;
  logic        kill_spec, rrf_we, rob_we;
  logic [5:0]  rob_tag;

  exunit_fpga #(.STAGES(STAGES)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .rrftag(rrftag), .dstval(dstval),
    .spectag(spectag), .specbit(specbit), .src1_signed(src1_signed),
    .src2_signed(src2_signed), .sel_lohi(sel_lohi), .prmiss(prmiss),
    .prsuccess(prsuccess), .prtag(prtag), .specfixtag(specfixtag),
    .exrslt(exrslt), .exdst(exdst), .kill_spec(kill_spec), .rrf_we(rrf_we),
    .rob_we(rob_we), .rob_tag(rob_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic        as, bs, sel;
    logic [5:0]  tag;
    logic        dst;
    logic [4:0]  stag;
    logic        sb;
    logic        alive;
    int          age;
  } op_t;

  op_t q[$];
  bit  rst_prev;
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Plain arithmetic: extend each operand per its flag, multiply in 64 bits.
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic as, input logic bs, input logic sel);
    longint x, y, p;
    x = as ? longint'($signed(a)) : longint'(a);
    y = bs ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return sel ? p[63:32] : p[31:0];
  endfunction

  task automatic model_check();
    op_t r;
    bit  have, k;
    have = (q.size() > 0) && (q[$].age == STAGES);
    if (rst_prev) begin
      chk("rst_exrslt", exrslt, 32'h0);
      chk("rst_exdst", exdst, 6'h0);
      chk("rst_robtag", rob_tag, 6'h0);
    end
    if (!have) begin
      chk("idle_kill_spec", kill_spec, 1'b1);
      chk("idle_rrf_we", rrf_we, 1'b0);
      chk("idle_rob_we", rob_we, 1'b0);
    end else begin
      r = q[$];
      k = prmiss && r.sb && ((r.stag & specfixtag) != 0);
      chk("kill_spec", kill_spec, !r.alive || !r.dst || k);
      chk("rrf_we", rrf_we, r.alive && r.dst && !k);
      chk("rob_we", rob_we, r.alive && !k);
      if (r.alive) begin
        chk("exrslt", exrslt, ref_mul(r.a, r.b, r.as, r.bs, r.sel));
        chk("exdst", exdst, r.tag);
        chk("rob_tag", rob_tag, r.tag);
      end
    end
  endtask

  task automatic model_step();
    op_t n;
    if (!reset) begin
      q.delete();
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      foreach (q[i]) begin
        if (q[i].age < STAGES) begin
          if (prmiss && q[i].sb && ((q[i].stag & specfixtag) != 0)) q[i].alive = 1'b0;
          else if (prsuccess && !prmiss && q[i].stag == prtag) q[i].sb = 1'b0;
        end
        q[i].age++;
      end
      while (q.size() > 0 && q[$].age > STAGES) void'(q.pop_back());
      n.a = ex_src1; n.b = ex_src2; n.as = src1_signed; n.bs = src2_signed;
      n.sel = sel_lohi; n.tag = rrftag; n.dst = dstval; n.stag = spectag;
      n.sb = specbit; n.alive = issue_valid; n.age = 1;
      if (prmiss && specbit && ((spectag & specfixtag) != 0)) n.alive = 1'b0;
      else if (prsuccess && !prmiss && spectag == prtag) n.sb = 1'b0;
      q.push_front(n);
    end
  endtask

  // Inputs already set; check this cycle, advance past the edge.
  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; prmiss = 1'b0; prsuccess = 1'b0;
    prtag = '0; specfixtag = '0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic as,
                       input logic bs, input logic sel, input logic [5:0] tag,
                       input logic dst, input logic [4:0] stag, input logic sb);
    issue_valid = 1'b1; ex_src1 = a; ex_src2 = b; src1_signed = as;
    src2_signed = bs; sel_lohi = sel; rrftag = tag; dstval = dst;
    spectag = stag; specbit = sb;
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_inputs();
    reset       = ($urandom_range(0, 99) != 0);
    issue_valid = ($urandom_range(0, 4) != 0);
    ex_src1     = rand_operand();
    ex_src2     = rand_operand();
    src1_signed = 1'($urandom_range(0, 1));
    src2_signed = 1'($urandom_range(0, 1));
    sel_lohi    = 1'($urandom_range(0, 1));
    rrftag      = 6'($urandom_range(0, 63));
    dstval      = ($urandom_range(0, 3) != 0);
    spectag     = 5'(1 << $urandom_range(0, 4));
    specbit     = 1'($urandom_range(0, 1));
    prmiss      = ($urandom_range(0, 6) == 0);
    prsuccess   = ($urandom_range(0, 3) == 0);
    prtag       = 5'(1 << $urandom_range(0, 4));
    specfixtag  = 5'($urandom_range(0, 31));
  endtask

  initial begin
    reset = 1'b0;
    idle();
    issue(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'h0, 1'b0, 5'h0, 1'b0);
    issue_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_prev = 1'b1;
    q.delete();

    // Post-reset outputs.
    chk("post_rst_kill_spec", kill_spec, 1'b1);
    chk("post_rst_rrf_we", rrf_we, 1'b0);
    chk("post_rst_rob_we", rob_we, 1'b0);
    chk("post_rst_exrslt", exrslt, 32'h0);
    reset = 1'b1;
    idle();
    cycle();

    // Unsigned high word.
    issue(32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0, 1'b1, 6'd5, 1'b1, 5'b0, 1'b0);
    cycle();
    idle();
    repeat (STAGES - 1) cycle();
    chk("unsigned_hi", exrslt, 32'h0000_0001);
    chk("unsigned_dst", exdst, 6'd5);
    chk("unsigned_rrf_we", rrf_we, 1'b1);
    chk("unsigned_rob_we", rob_we, 1'b1);
    chk("unsigned_kill_spec", kill_spec, 1'b0);

    // Signed low then signed high, back to back.
    issue(32'hFFFF_FFFF, 32'h3, 1'b1, 1'b1, 1'b0, 6'd7, 1'b1, 5'b0, 1'b0);
    cycle();
    issue(32'hFFFF_FFFF, 32'h3, 1'b1, 1'b1, 1'b1, 6'd8, 1'b1, 5'b0, 1'b0);
    cycle();
    idle();
    repeat (STAGES - 2) cycle();
    chk("signed_lo", exrslt, 32'hFFFF_FFFD);
    cycle();
    chk("signed_hi", exrslt, 32'hFFFF_FFFF);
    repeat (STAGES) cycle();

    // Back-to-back tags 0..5.
    for (int i = 0; i < 6; i++) begin
      issue($urandom, $urandom, 1'b0, 1'b1, 1'b0, 6'(i), 1'b1, 5'b0, 1'b0);
      cycle();
    end
    idle();
    repeat (STAGES + 1) cycle();

    // Mispredict kills a speculative op; following non-speculative op completes.
    issue(32'd10, 32'd20, 1'b0, 1'b0, 1'b0, 6'd9, 1'b1, 5'b00100, 1'b1);
    cycle();
    issue(32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 6'd10, 1'b1, 5'b00100, 1'b0);
    prmiss = 1'b1; specfixtag = 5'b00110;
    cycle();
    idle();
    repeat (STAGES - 2) cycle();
    chk("killed_rob_we", rob_we, 1'b0);
    chk("killed_kill_spec", kill_spec, 1'b1);
    cycle();
    chk("survivor_rob_we", rob_we, 1'b1);
    chk("survivor_rslt", exrslt, 32'd12);
    repeat (STAGES) cycle();

    // Resolve then mispredict on the same tag: op survives.
    issue(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, 6'd11, 1'b1, 5'b00010, 1'b1);
    cycle();
    idle();
    prsuccess = 1'b1; prtag = 5'b00010;
    cycle();
    idle();
    prmiss = 1'b1; specfixtag = 5'b00010;
    cycle();
    idle();
    chk("resolved_rob_we", rob_we, 1'b1);
    chk("resolved_dst", exdst, 6'd11);
    repeat (STAGES) cycle();

    // Reset with two ops in flight.
    issue(32'd1, 32'd1, 1'b0, 1'b0, 1'b0, 6'd12, 1'b1, 5'b0, 1'b0);
    cycle();
    issue(32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 6'd13, 1'b1, 5'b0, 1'b0);
    cycle();
    idle();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    for (int i = 0; i < STAGES + 2; i++) begin
      chk("flushed_rob_we", rob_we, 1'b0);
      chk("flushed_kill_spec", kill_spec, 1'b1);
      cycle();
    end

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
